axi4_mem_ctrl: RTL and testbench
================================

# axi4_mem_ctrl

AXI4 slave-side controller that sequences the single-port `axi4_memory` array: it accepts AXI4 INCR bursts on independent read and write channels, arbitrates between them, and drives the memory's `mem_en`/`mem_we`/`mem_addr`/`mem_wdata` port, returning `mem_rdata` on R. It sits between the AXI interconnect and `axi4_memory` and is the only master of the memory port. It keeps at most one burst in flight; reads and writes never overlap.

## Interface
- `DATA_WIDTH`, default 32: AXI and memory data width; only 4-byte beats are legal.
- `ADDR_WIDTH`, default 16: AXI byte-address width.
- `MEM_ADDR_WIDTH`, default 10: memory word-address width.
- `DEPTH`, default 1024: number of memory words.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `awaddr` in `ADDR_WIDTH`, `awlen` in 8, `awsize` in 3, `awburst` in 2, `awvalid` in 1, `awready` out 1: write address channel.
- `wdata` in `DATA_WIDTH`, `wlast` in 1, `wvalid` in 1, `wready` out 1: write data channel.
- `bresp` out 2, `bvalid` out 1, `bready` in 1: write response channel.
- `araddr` in `ADDR_WIDTH`, `arlen` in 8, `arsize` in 3, `arburst` in 2, `arvalid` in 1, `arready` out 1: read address channel.
- `rdata` out `DATA_WIDTH`, `rresp` out 2, `rlast` out 1, `rvalid` out 1, `rready` in 1: read data channel.
- `mem_en` out 1, `mem_we` out 1, `mem_addr` out `MEM_ADDR_WIDTH`, `mem_wdata` out `DATA_WIDTH`: memory command.
- `mem_rdata` in `DATA_WIDTH`: memory read data. It is registered and valid the cycle after an enabled read.

## Operation
- FSM states:
  - IDLE
  - WR_DATA, WR_RESP
  - RD_ISSUE, RD_CAPTURE, RD_DATA
- **IDLE arbitration.**
  - `awready` = write granted; `arready` = read granted.
  - Only one is high in a cycle, and only in IDLE.
  - If only one valid is high, grant it.
  - If both are high, grant the channel not served last (round-robin flag). Reset sets the flag so write wins the first tie.
  - On handshake, latch word address = addr[MEM_ADDR_WIDTH+1:2], the beat count `len`, and the error flag.
- **Error flag (SLVERR = 2'b10)** is set if any of the following holds; otherwise OKAY = 2'b00:
  - size != 3'b010;
  - burst != 2'b01 (INCR);
  - addr[1:0] != 0;
  - start word + len > DEPTH-1.
- **Write (WR_DATA).**
  - `wready` = 1.
  - Each `wvalid`&`wready` beat drives `mem_en`=`mem_we`=1 combinationally, with `mem_addr` = current word and `mem_wdata` = `wdata`.
  - On error, `mem_en` stays 0 and no memory write occurs.
  - The word address increments per beat.
  - After beat len+1 (counter-based), go to WR_RESP.
  - If `wlast` disagrees with the counter on any beat, set SLVERR. The burst length is still governed by the counter.
- **WR_RESP.** `bvalid`=1 with `bresp`; on `bready` go to IDLE.
- **Read, per beat.**
  - RD_ISSUE: `mem_en`=1, `mem_we`=0, `mem_addr` = current word; `mem_en`=0 on error.
  - RD_CAPTURE: load `rdata` register from `mem_rdata`, or 0 on error.
  - RD_DATA: `rvalid`=1, `rresp` = error flag, `rlast` = final beat.
  - On `rready`: if more beats remain, increment the address and go to RD_ISSUE; otherwise go to IDLE.
- **Idle memory port.** `mem_en`=0 in all states other than those above. `mem_wdata`/`mem_addr` values are don't-care when `mem_en`=0.
- **Data stability.** R/B outputs hold stable while valid is high and ready is low.

## Timing
- **Reset:**
  - state IDLE;
  - `awready`, `wready`, `bvalid`, `arready`, `rvalid`, `rlast`, `mem_en`, `mem_we` = 0;
  - `bresp`, `rresp`, `rdata`, `mem_addr`, `mem_wdata` = 0.
- **Reset mid-burst:** abort on the next edge. No further memory writes and no B/R response for the aborted burst.
- **Write latency:**
  - AW handshake at edge N; `wready` high in cycle N+1.
  - A beat accepted at edge M is written to memory at edge M.
  - `bvalid` rises the cycle after the last beat.
  - Minimum L-beat write: L+2 cycles to the B handshake.
- **Read latency:**
  - AR handshake in cycle 0; RD_ISSUE in cycle 1, RD_CAPTURE in cycle 2, `rvalid` in cycle 3.
  - Each further beat takes 3 cycles plus any `rready` stall.
- **New grants:** a new grant is possible in the first IDLE cycle after a B or final R handshake.

## Test plan
- **Single write, then read.**
  - Stimulus: AW addr 0x0010, len 0, W 0xDEADBEEF; then AR 0x0010, len 0.
  - Required: mem[4] = 0xDEADBEEF, `bresp`=0, `rdata`=0xDEADBEEF, `rlast`=1, `rresp`=0.
- **Burst.**
  - Stimulus: write 4 beats at 0x0100 (data 1,2,3,4), read back len 3.
  - Required: mem[64..67] = 1..4; R returns 1,2,3,4 with `rlast` only on the 4th beat; first `rvalid` 3 cycles after the AR handshake.
- **Arbitration.**
  - Stimulus: `awvalid` and `arvalid` asserted together in the first cycle after reset, repeated twice.
  - Required: write granted first, then read, then write. `awready` and `arready` are never high together.
- **Errors.**
  - AW 0x0FF8 with len 3 (words 1022..1025) → `mem_en` never high, `bresp`=2'b10.
  - AR with `arburst`=2'b00 → each beat `rdata`=0, `rresp`=2'b10.
- **Backpressure.** Stimulus: hold `bready`/`rready` low for 5 cycles. Required: `bvalid`/`rvalid` and the data stay stable, and no new grant or memory access occurs.
- **Reset mid-burst.**
  - Stimulus: assert `rst` after beat 2 of a 4-beat write.
  - Required: all outputs reach their reset values the next cycle, mem[beats 3,4] unchanged, and no `bvalid`.

Source files
------------

// File: rtl/axi4_mem_ctrl.sv
// axi4_mem_ctrl: AXI4 slave controller in front of a single-port word memory.
// Accepts INCR bursts on independent read and write channels. It arbitrates
// round-robin in IDLE, keeps one burst in flight, and sequences the memory
// command port. Read data is captured from the registered memory output
// before it is presented on R.
module axi4_mem_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 16,
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int DEPTH          = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    // write address channel
    input  logic [ADDR_WIDTH-1:0]     awaddr,
    input  logic [7:0]                awlen,
    input  logic [2:0]                awsize,
    input  logic [1:0]                awburst,
    input  logic                      awvalid,
    output logic                      awready,
    // write data channel
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic                      wlast,
    input  logic                      wvalid,
    output logic                      wready,
    // write response channel
    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,
    // read address channel
    input  logic [ADDR_WIDTH-1:0]     araddr,
    input  logic [7:0]                arlen,
    input  logic [2:0]                arsize,
    input  logic [1:0]                arburst,
    input  logic                      arvalid,
    output logic                      arready,
    // read data channel
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic [1:0]                rresp,
    output logic                      rlast,
    output logic                      rvalid,
    input  logic                      rready,
    // memory command port
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    // debug: current FSM state encoding
    output logic [2:0]                state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high. Valid is never withdrawn by this block before its ready
    // partner, and bresp/rdata/rresp/rlast are held constant while
    // bvalid/rvalid wait for ready.

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WR_DATA    = 3'd1,
        WR_RESP    = 3'd2,
        RD_ISSUE   = 3'd3,
        RD_CAPTURE = 3'd4,
        RD_DATA    = 3'd5
    } state_t;

    state_t                    state;
    logic [MEM_ADDR_WIDTH-1:0] word_addr;
    logic [7:0]                beat_len;
    logic [7:0]                beat_cnt;
    logic                      burst_err;
    logic                      wlast_err;
    logic                      last_was_write;

    logic                      aw_grant;
    logic                      ar_grant;
    logic                      aw_err;
    logic                      ar_err;
    logic [31:0]               aw_end_word;
    logic [31:0]               ar_end_word;
    logic                      wr_beat;
    logic                      last_beat;
    logic                      beat_wlast_err;
    logic                      unused_addr_bits;

    // Bits above the memory word index alias onto the array; [1:0] only feed the error check.
    assign unused_addr_bits = ^{awaddr, araddr};

    // Burst legality: 4-byte beats, INCR only, word aligned, and the last word inside the array.
    assign aw_end_word = 32'(awaddr[MEM_ADDR_WIDTH+1:2]) + 32'(awlen);
    assign ar_end_word = 32'(araddr[MEM_ADDR_WIDTH+1:2]) + 32'(arlen);
    assign aw_err = (awsize != 3'b010) || (awburst != 2'b01) ||
                    (awaddr[1:0] != 2'b00) || (aw_end_word > 32'(DEPTH - 1));
    assign ar_err = (arsize != 3'b010) || (arburst != 2'b01) ||
                    (araddr[1:0] != 2'b00) || (ar_end_word > 32'(DEPTH - 1));

    // Round-robin grant: on a tie the channel not served last wins.
    assign aw_grant = !rst && (state == IDLE) && awvalid && (!arvalid || !last_was_write);
    assign ar_grant = !rst && (state == IDLE) && arvalid && !aw_grant;
    assign awready  = aw_grant;
    assign arready  = ar_grant;

    assign last_beat      = (beat_cnt == beat_len);
    assign wr_beat        = !rst && (state == WR_DATA) && wvalid && wready;
    assign beat_wlast_err = wlast_err || (wlast != last_beat);

    // Memory command is decoded from the state; reset suppresses it at once so an
    // aborted burst cannot write on the reset edge.
    assign mem_we    = wr_beat && !burst_err;
    assign mem_en    = mem_we || (!rst && (state == RD_ISSUE) && !burst_err);
    assign mem_addr  = word_addr;
    assign mem_wdata = mem_we ? wdata : '0;
    assign state_dbg = state;

    // Burst sequencer: grant, walk the word address per beat, and produce B/R responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            word_addr      <= '0;
            beat_len       <= '0;
            beat_cnt       <= '0;
            burst_err      <= 1'b0;
            wlast_err      <= 1'b0;
            last_was_write <= 1'b0;
            wready         <= 1'b0;
            bvalid         <= 1'b0;
            bresp          <= RESP_OKAY;
            rvalid         <= 1'b0;
            rlast          <= 1'b0;
            rresp          <= RESP_OKAY;
            rdata          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (aw_grant) begin
                        word_addr      <= awaddr[MEM_ADDR_WIDTH+1:2];
                        beat_len       <= awlen;
                        beat_cnt       <= '0;
                        burst_err      <= aw_err;
                        wlast_err      <= 1'b0;
                        last_was_write <= 1'b1;
                        wready         <= 1'b1;
                        state          <= WR_DATA;
                    end else if (ar_grant) begin
                        word_addr      <= araddr[MEM_ADDR_WIDTH+1:2];
                        beat_len       <= arlen;
                        beat_cnt       <= '0;
                        burst_err      <= ar_err;
                        last_was_write <= 1'b0;
                        state          <= RD_ISSUE;
                    end
                end
                WR_DATA: begin
                    if (wr_beat) begin
                        wlast_err <= beat_wlast_err;
                        word_addr <= word_addr + MEM_ADDR_WIDTH'(1);
                        beat_cnt  <= beat_cnt + 8'd1;
                        if (last_beat) begin
                            wready <= 1'b0;
                            bvalid <= 1'b1;
                            bresp  <= (burst_err || beat_wlast_err) ? RESP_SLVERR : RESP_OKAY;
                            state  <= WR_RESP;
                        end
                    end
                end
                WR_RESP: begin
                    if (bready) begin
                        bvalid <= 1'b0;
                        state  <= IDLE;
                    end
                end
                RD_ISSUE: begin
                    state <= RD_CAPTURE;
                end
                RD_CAPTURE: begin
                    rdata  <= burst_err ? '0 : mem_rdata;
                    rresp  <= burst_err ? RESP_SLVERR : RESP_OKAY;
                    rlast  <= last_beat;
                    rvalid <= 1'b1;
                    state  <= RD_DATA;
                end
                RD_DATA: begin
                    if (rready) begin
                        rvalid <= 1'b0;
                        rlast  <= 1'b0;
                        if (last_beat) begin
                            state <= IDLE;
                        end else begin
                            word_addr <= word_addr + MEM_ADDR_WIDTH'(1);
                            beat_cnt  <= beat_cnt + 8'd1;
                            state     <= RD_ISSUE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_mem_ctrl.sv
// tb_axi4_mem_ctrl: directed bench for axi4_mem_ctrl with a behavioural
// single-port memory (registered read data, one cycle after an enabled read).
module tb_axi4_mem_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [15:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        mem_en;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [2:0]  state_dbg;

    logic [31:0] mem [0:1023];
    logic        mem_init;
    int          mem_en_cnt;
    int          mem_wr_cnt;
    logic        both_ready_seen;

    logic [31:0] wbuf [0:7];
    logic [31:0] rbuf [0:7];

    int n_tests;
    int n_fail;
    int snap_en;
    int snap_wr;

    axi4_mem_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .awaddr    (awaddr),
        .awlen     (awlen),
        .awsize    (awsize),
        .awburst   (awburst),
        .awvalid   (awvalid),
        .awready   (awready),
        .wdata     (wdata),
        .wlast     (wlast),
        .wvalid    (wvalid),
        .wready    (wready),
        .bresp     (bresp),
        .bvalid    (bvalid),
        .bready    (bready),
        .araddr    (araddr),
        .arlen     (arlen),
        .arsize    (arsize),
        .arburst   (arburst),
        .arvalid   (arvalid),
        .arready   (arready),
        .rdata     (rdata),
        .rresp     (rresp),
        .rlast     (rlast),
        .rvalid    (rvalid),
        .rready    (rready),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    // Preload value of word i is 32'hC0DE_0000 | i.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
            mem_rdata  <= '0;
            mem_en_cnt <= 0;
            mem_wr_cnt <= 0;
        end else if (mem_en) begin
            mem_en_cnt <= mem_en_cnt + 1;
            if (mem_we) begin
                mem[mem_addr] <= mem_wdata;
                mem_wr_cnt    <= mem_wr_cnt + 1;
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
    end

    // Watch for both address channels being granted in the same cycle.
    initial both_ready_seen = 1'b0;
    always begin
        @(negedge clk);
        #2;
        if (awready && arready) both_ready_seen = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard check ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_state"},     32'(state_dbg), 32'd0);
        chk({tag, "_awready"},   32'(awready),   32'd0);
        chk({tag, "_arready"},   32'(arready),   32'd0);
        chk({tag, "_wready"},    32'(wready),    32'd0);
        chk({tag, "_bvalid"},    32'(bvalid),    32'd0);
        chk({tag, "_rvalid"},    32'(rvalid),    32'd0);
        chk({tag, "_rlast"},     32'(rlast),     32'd0);
        chk({tag, "_mem_en"},    32'(mem_en),    32'd0);
        chk({tag, "_mem_we"},    32'(mem_we),    32'd0);
        chk({tag, "_bresp"},     32'(bresp),     32'd0);
        chk({tag, "_rresp"},     32'(rresp),     32'd0);
        chk({tag, "_rdata"},     rdata,          32'd0);
        chk({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata,      32'd0);
    endtask

    // ---------------- driver tasks ----------------
    // All drivers are entered just after a falling edge and return just after one.
    task automatic do_aw(input logic [15:0] a, input logic [7:0] l,
                         input logic [2:0] s, input logic [1:0] b);
        int n;
        awaddr = a; awlen = l; awsize = s; awburst = b; awvalid = 1'b1;
        n = 0;
        #1;
        while (!awready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("aw_grant", 32'(awready), 32'd1);
        @(negedge clk);
        awvalid = 1'b0;
    endtask

    task automatic do_ar(input logic [15:0] a, input logic [7:0] l,
                         input logic [2:0] s, input logic [1:0] b);
        int n;
        araddr = a; arlen = l; arsize = s; arburst = b; arvalid = 1'b1;
        n = 0;
        #1;
        while (!arready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("ar_grant", 32'(arready), 32'd1);
        @(negedge clk);
        arvalid = 1'b0;
    endtask

    // Send n beats of a total-beat burst; beat 'bad' carries an inverted wlast.
    task automatic do_w(input int n, input int total, input int bad,
                        input int base, input bit exp_wr);
        for (int i = 0; i < n; i++) begin
            int w;
            wdata  = wbuf[i];
            wlast  = ((i == total - 1) != (i == bad));
            wvalid = 1'b1;
            w = 0;
            #1;
            while (!wready && w < 20) begin
                @(negedge clk); #1; w++;
            end
            chk("w_ready_wait", 32'(w), 32'd0);
            @(negedge clk);
            if (exp_wr) chk("mem_write", mem[10'(base + i)], wbuf[i]);
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
    endtask

    task automatic do_b(input logic [1:0] exp_resp, input int stall);
        int w;
        int snap;
        w = 0;
        #1;
        while (!bvalid && w < 20) begin
            @(negedge clk); #1; w++;
        end
        chk("b_latency", 32'(w), 32'd0);
        chk("bresp", 32'(bresp), 32'(exp_resp));
        if (stall > 0) begin
            snap = mem_en_cnt;
            arvalid = 1'b1;
            for (int k = 0; k < stall; k++) begin
                @(negedge clk); #1;
                chk("b_stall_bvalid",  32'(bvalid),  32'd1);
                chk("b_stall_bresp",   32'(bresp),   32'(exp_resp));
                chk("b_stall_arready", 32'(arready), 32'd0);
                chk("b_stall_mem",     32'(mem_en_cnt), 32'(snap));
            end
            arvalid = 1'b0;
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic do_r(input int n, input logic [1:0] exp_resp, input int stall);
        for (int i = 0; i < n; i++) begin
            int w;
            int snap;
            w = 0;
            #1;
            while (!rvalid && w < 20) begin
                @(negedge clk); #1; w++;
            end
            chk("r_latency", 32'(w), 32'd2);
            chk("rdata", rdata, rbuf[i]);
            chk("rresp", 32'(rresp), 32'(exp_resp));
            chk("rlast", 32'(rlast), 32'(i == n - 1));
            if (stall > 0 && i == 0) begin
                snap = mem_en_cnt;
                awvalid = 1'b1;
                for (int k = 0; k < stall; k++) begin
                    @(negedge clk); #1;
                    chk("r_stall_rvalid",  32'(rvalid),  32'd1);
                    chk("r_stall_rdata",   rdata,        rbuf[i]);
                    chk("r_stall_rlast",   32'(rlast),   32'(i == n - 1));
                    chk("r_stall_awready", 32'(awready), 32'd0);
                    chk("r_stall_mem",     32'(mem_en_cnt), 32'(snap));
                end
                awvalid = 1'b0;
            end
            rready = 1'b1;
            @(negedge clk);
            rready = 1'b0;
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1; mem_init = 1'b1;
        awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_reset("reset");

        // Arbitration: tie right after reset -> write, then read, then write.
        @(negedge clk);
        rst = 1'b0; mem_init = 1'b0;
        awaddr = 16'h0020; awlen = 8'd0; awsize = 3'b010; awburst = 2'b01;
        araddr = 16'h0020; arlen = 8'd0; arsize = 3'b010; arburst = 2'b01;
        awvalid = 1'b1; arvalid = 1'b1;
        #1;
        chk("arb1_awready", 32'(awready), 32'd1);
        chk("arb1_arready", 32'(arready), 32'd0);
        @(negedge clk);
        awvalid = 1'b0;
        wbuf[0] = 32'h1111_1111;
        do_w(1, 1, -1, 8, 1'b1);
        do_b(2'b00, 0);
        awaddr = 16'h0024; awvalid = 1'b1;
        #1;
        chk("arb2_arready", 32'(arready), 32'd1);
        chk("arb2_awready", 32'(awready), 32'd0);
        @(negedge clk);
        arvalid = 1'b0;
        rbuf[0] = 32'h1111_1111;
        do_r(1, 2'b00, 0);
        arvalid = 1'b1;
        #1;
        chk("arb3_awready", 32'(awready), 32'd1);
        chk("arb3_arready", 32'(arready), 32'd0);
        @(negedge clk);
        awvalid = 1'b0; arvalid = 1'b0;
        wbuf[0] = 32'h2222_2222;
        do_w(1, 1, -1, 9, 1'b1);
        do_b(2'b00, 0);
        chk("arb_mem8", mem[8], 32'h1111_1111);
        chk("arb_mem9", mem[9], 32'h2222_2222);

        // Single write then read at 0x0010 (word 4).
        do_aw(16'h0010, 8'd0, 3'b010, 2'b01);
        wbuf[0] = 32'hDEAD_BEEF;
        do_w(1, 1, -1, 4, 1'b1);
        do_b(2'b00, 0);
        chk("single_mem4", mem[4], 32'hDEAD_BEEF);
        do_ar(16'h0010, 8'd0, 3'b010, 2'b01);
        rbuf[0] = 32'hDEAD_BEEF;
        do_r(1, 2'b00, 0);

        // 4-beat burst at 0x0100 (words 64..67), with B and R backpressure.
        do_aw(16'h0100, 8'd3, 3'b010, 2'b01);
        for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
        do_w(4, 4, -1, 64, 1'b1);
        do_b(2'b00, 5);
        for (int i = 0; i < 4; i++) chk("burst_mem", mem[64 + i], 32'(i + 1));
        do_ar(16'h0100, 8'd3, 3'b010, 2'b01);
        for (int i = 0; i < 4; i++) rbuf[i] = 32'(i + 1);
        do_r(4, 2'b00, 5);

        // Out-of-range write: words 1022..1025, no memory access at all.
        snap_en = mem_en_cnt;
        do_aw(16'h0FF8, 8'd3, 3'b010, 2'b01);
        for (int i = 0; i < 4; i++) wbuf[i] = 32'h5A5A_0000 | 32'(i);
        do_w(4, 4, -1, 0, 1'b0);
        do_b(2'b10, 0);
        chk("err_wr_mem_en", 32'(mem_en_cnt), 32'(snap_en));
        chk("err_wr_mem1022", mem[1022], 32'hC0DE_03FE);
        chk("err_wr_mem1023", mem[1023], 32'hC0DE_03FF);

        // Fixed-burst read: zero data and SLVERR on every beat, no memory access.
        snap_en = mem_en_cnt;
        do_ar(16'h0010, 8'd1, 3'b010, 2'b00);
        rbuf[0] = 32'h0; rbuf[1] = 32'h0;
        do_r(2, 2'b10, 0);
        chk("err_rd_mem_en", 32'(mem_en_cnt), 32'(snap_en));

        // Early wlast on the first beat of a 2-beat write.
        do_aw(16'h0040, 8'd1, 3'b010, 2'b01);
        wbuf[0] = 32'h3333_0000; wbuf[1] = 32'h3333_0001;
        do_w(2, 2, 0, 0, 1'b0);
        do_b(2'b10, 0);

        // Reset after beat 2 of a 4-beat write at 0x0200 (words 128..131).
        snap_wr = mem_wr_cnt;
        do_aw(16'h0200, 8'd3, 3'b010, 2'b01);
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hB000_0001 + 32'(i);
        do_w(2, 4, -1, 128, 1'b1);
        wdata = wbuf[2]; wlast = 1'b0; wvalid = 1'b1; rst = 1'b1;
        @(negedge clk);
        #1;
        chk_reset("mid_rst");
        chk("mid_rst_writes", 32'(mem_wr_cnt - snap_wr), 32'd2);
        chk("mid_rst_mem130", mem[130], 32'hC0DE_0082);
        chk("mid_rst_mem131", mem[131], 32'hC0DE_0083);
        rst = 1'b0; wvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            chk("mid_rst_no_bvalid", 32'(bvalid), 32'd0);
            chk("mid_rst_idle", 32'(state_dbg), 32'd0);
        end
        chk("mid_rst_mem130_after", mem[130], 32'hC0DE_0082);

        chk("never_both_ready", 32'(both_ready_seen), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
